mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS core; sits directly upstream of the ALU and drives

---
 rtl/mips_multicycle_ctrl_pkg.sv | 76 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 36 +++
 rtl/mips_multicycle_ctrl_decode.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, ALU/PC select codes,
// FSM state encoding, instruction classes and the bundled control-output struct.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_OR  = 2'b01,
        ALU_SUB = 2'b10,
        ALU_LUI = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILLEGAL
    } kind_e;

    typedef struct packed {
        logic    pc_write;
        pc_src_e pc_src;
        logic    ir_write;
        logic    imem_read;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    reg_dst;
        logic    mem_to_reg;
        alu_op_e alu_op;
        logic    alu_src;
        logic    ext_sign;
        logic    illegal;
    } ctrl_t;

    // First state after DECODE for each instruction class.
    function automatic state_e kind_to_state(input kind_e k);
        case (k)
            K_ADDU, K_SUBU: return S_EXEC_R;
            K_ORI, K_LUI:   return S_EXEC_I;
            K_LW, K_SW:     return S_MEM_ADDR;
            K_BEQ:          return S_BRANCH;
            K_J:            return S_JUMP;
            default:        return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface mips_multicycle_ctrl_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [31:0]            instr;
    logic                   alu_zero;
    logic                   mem_ready;
    logic                   pc_write;
    logic [1:0]             pc_src;
    logic                   ir_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   imem_read;
    logic                   reg_write;
    logic                   select_regDst;
    logic                   select_memToReg;
    logic [1:0]             select_aluPerformance;
    logic                   select_anotherAluSource;
    logic                   ext_sign;
    logic                   illegal_instr;
    logic [COUNT_WIDTH-1:0] retire_count;

    modport master (
        input  instr, alu_zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, imem_read, reg_write,
               select_regDst, select_memToReg, select_aluPerformance,
               select_anotherAluSource, ext_sign, illegal_instr, retire_count
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, imem_read, reg_write,
               select_regDst, select_memToReg, select_aluPerformance,
               select_anotherAluSource, ext_sign, illegal_instr, retire_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class + illegal flag.
module mips_multicycle_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output kind_e      kind_o,
    output logic       illegal_o
);

    always_comb begin
        kind_o = K_ILLEGAL;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_ADDU) begin
                    kind_o = K_ADDU;
                end else if (funct_i == FN_SUBU) begin
                    kind_o = K_SUBU;
                end
            end
            OP_ORI:  kind_o = K_ORI;
            OP_LUI:  kind_o = K_LUI;
            OP_LW:   kind_o = K_LW;
            OP_SW:   kind_o = K_SW;
            OP_BEQ:  kind_o = K_BEQ;
            OP_J:    kind_o = K_J;
            default: kind_o = K_ILLEGAL;
        endcase
    end

    assign illegal_o = (kind_o == K_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state/output decode and retire counter.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] retire_q, retire_d;
    logic                   retire;
    kind_e                  kind;
    logic                   illegal;
    ctrl_t                  ctrl;
    logic                   unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[25:6];

    mips_multicycle_ctrl_decode u_decode (
        .opcode_i  (bus.instr[31:26]),
        .funct_i   (bus.instr[5:0]),
        .kind_o    (kind),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.imem_read = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SEQ;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: state_d = illegal ? S_TRAP : kind_to_state(kind);
            S_EXEC_R: begin
                ctrl.alu_op = (kind == K_SUBU) ? ALU_SUB : ALU_ADD;
                state_d     = S_WB_R;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXEC_I: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = (kind == K_LUI) ? ALU_LUI : ALU_OR;
                state_d      = S_WB_I;
            end
            S_WB_I: begin
                ctrl.reg_write = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src  = 1'b1;
                ctrl.ext_sign = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                state_d       = (kind == K_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire          = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                // Mealy: only a zero ALU result redirects the PC.
                ctrl.alu_op   = ALU_SUB;
                ctrl.pc_write = bus.alu_zero;
                ctrl.pc_src   = PC_BRANCH;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP:  ctrl.illegal = 1'b1;
            default: state_d = S_TRAP;
        endcase
        // Outputs stay quiet for the whole time reset is held, not just after the edge.
        if (reset) begin
            ctrl = '0;
        end
    end

    assign retire_d = retire ? retire_q + COUNT_WIDTH'(1) : retire_q;

    assign bus.pc_write                = ctrl.pc_write;
    assign bus.pc_src                  = ctrl.pc_src;
    assign bus.ir_write                = ctrl.ir_write;
    assign bus.imem_read               = ctrl.imem_read;
    assign bus.mem_read                = ctrl.mem_read;
    assign bus.mem_write               = ctrl.mem_write;
    assign bus.reg_write               = ctrl.reg_write;
    assign bus.select_regDst           = ctrl.reg_dst;
    assign bus.select_memToReg         = ctrl.mem_to_reg;
    assign bus.select_aluPerformance   = ctrl.alu_op;
    assign bus.select_anotherAluSource = ctrl.alu_src;
    assign bus.ext_sign                = ctrl.ext_sign;
    assign bus.illegal_instr           = ctrl.illegal;
    assign bus.retire_count            = retire_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: a driver issues random instructions and pushes per-instruction expectations;
// a monitor summarises DUT activity per retired instruction and compares against them.
module tb_mips_multicycle_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mips_multicycle_ctrl_if #(.COUNT_WIDTH(CW)) bus ();
    mips_multicycle_ctrl #(.COUNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        int lat; int imem; int mrd; int mwr; int rw; int rdst; int m2r; int pcw;
        int psrc; int op; int src; int ext; int irw; int dual; int cnt;
    } summ_t;

    summ_t q[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic summ_t zero_summ();
        summ_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Reference: what one instruction should look like from outside, given its stall plan.
    function automatic summ_t model(input string nm, input int fs, input int ms, input logic z);
        summ_t e = zero_summ();
        e.imem = fs + 1;
        e.irw  = 1;
        e.pcw  = 1;
        case (nm)
            "addu": begin e.lat = 4; e.rw = 1; e.rdst = 1; e.op = 0; end
            "subu": begin e.lat = 4; e.rw = 1; e.rdst = 1; e.op = 2; end
            "ori":  begin e.lat = 4; e.rw = 1; e.op = 1; e.src = 1; end
            "lui":  begin e.lat = 4; e.rw = 1; e.op = 3; e.src = 1; end
            "lw":   begin e.lat = 5 + ms; e.rw = 1; e.m2r = 1; e.src = 1; e.ext = 1; e.mrd = ms + 1; end
            "sw":   begin e.lat = 4 + ms; e.src = 1; e.ext = 1; e.mwr = ms + 1; end
            "beq":  begin e.lat = 3; e.op = 2; e.psrc = 1; e.pcw = 1 + int'(z); end
            default: begin e.lat = 3; e.psrc = 2; e.pcw = 2; end
        endcase
        e.lat += fs;
        return e;
    endfunction

    // Monitor: accumulate one instruction's activity, compare when retire_count moves.
    initial begin : monitor
        summ_t o;
        summ_t e;
        int cyc;
        int ir_idx;
        logic [CW-1:0] last;
        o = zero_summ(); cyc = 0; ir_idx = -1; last = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                o = zero_summ(); cyc = 0; ir_idx = -1; last = '0;
                continue;
            end
            if (bus.retire_count != last) begin
                if (q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = q.pop_front();
                    o.lat = cyc;
                    o.cnt = int'(bus.retire_count);
                    chk("latency", o.lat, e.lat);
                    chk("imem_read_cycles", o.imem, e.imem);
                    chk("mem_read_cycles", o.mrd, e.mrd);
                    chk("mem_write_cycles", o.mwr, e.mwr);
                    chk("reg_write_cycles", o.rw, e.rw);
                    chk("regDst", o.rdst, e.rdst);
                    chk("memToReg", o.m2r, e.m2r);
                    chk("pc_write_cycles", o.pcw, e.pcw);
                    chk("pc_src_exec", o.psrc, e.psrc);
                    chk("alu_op_exec", o.op, e.op);
                    chk("alu_src_exec", o.src, e.src);
                    chk("ext_sign_exec", o.ext, e.ext);
                    chk("ir_write_cycles", o.irw, e.irw);
                    chk("dual_mem_request", o.dual, e.dual);
                    chk("retire_count", o.cnt, e.cnt);
                end
                last = bus.retire_count;
                o = zero_summ(); cyc = 0; ir_idx = -1;
            end
            o.imem += int'(bus.imem_read);
            o.mrd  += int'(bus.mem_read);
            o.mwr  += int'(bus.mem_write);
            o.rw   += int'(bus.reg_write);
            o.pcw  += int'(bus.pc_write);
            o.irw  += int'(bus.ir_write);
            if (bus.select_regDst)   o.rdst = 1;
            if (bus.select_memToReg) o.m2r = 1;
            if (int'(bus.imem_read) + int'(bus.mem_read) + int'(bus.mem_write) > 1) o.dual++;
            if (bus.ir_write && ir_idx < 0) ir_idx = cyc;
            if (ir_idx >= 0 && cyc == ir_idx + 2) begin
                o.psrc = int'(bus.pc_src);
                o.op   = int'(bus.select_aluPerformance);
                o.src  = int'(bus.select_anotherAluSource);
                o.ext  = int'(bus.ext_sign);
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] w, input bit is_mem, input int fs, input int ms,
                             input logic z);
        int n = 0;
        while (!bus.imem_read && n < 20) begin
            bus.mem_ready = 1'($urandom);
            tick();
            n++;
        end
        chk("fetch_wait_bound", int'(bus.imem_read), 1);
        bus.instr     = w;
        bus.alu_zero  = z;
        bus.mem_ready = 1'b0;
        repeat (fs) tick();
        bus.mem_ready = 1'b1;
        tick();
        if (is_mem) begin
            n = 0;
            while (!(bus.mem_read || bus.mem_write) && n < 10) begin
                bus.mem_ready = 1'($urandom);
                tick();
                n++;
            end
            chk("mem_wait_bound", int'(bus.mem_read || bus.mem_write), 1);
            bus.mem_ready = 1'b0;
            repeat (ms) tick();
            bus.mem_ready = 1'b1;
            tick();
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] w, input int fs, input int ms,
                         input logic z);
        summ_t e = model(nm, fs, ms, z);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        e.cnt = exp_cnt;
        q.push_back(e);
        run_instr(w, (nm == "lw" || nm == "sw"), fs, ms, z);
    endtask

    task automatic drain();
        int n = 0;
        bus.mem_ready = 1'b0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("queue_drain", q.size(), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_enables"}, int'({bus.pc_write, bus.ir_write, bus.imem_read, bus.mem_read,
                                     bus.mem_write, bus.reg_write}), 0);
        chk({tag, "_selects"}, int'({bus.pc_src, bus.select_regDst, bus.select_memToReg,
                                     bus.select_aluPerformance, bus.select_anotherAluSource,
                                     bus.ext_sign}), 0);
    endtask

    initial begin : stimulus
        string names [8] = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq", "j"};
        logic [31:0] w;
        int k, fs, ms;
        logic z;

        bus.instr = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_illegal", int'(bus.illegal_instr), 0);
        chk("reset_retire_count", int'(bus.retire_count), 0);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_reset_imem_read", int'(bus.imem_read), 1);

        issue("addu", 32'h00221821, 0, 0, 1'b0);
        issue("ori",  32'h34020093, 0, 0, 1'b0);
        issue("lw",   32'h8C040008, 0, 2, 1'b0);
        issue("beq",  32'h10220004, 0, 0, 1'b1);
        issue("beq",  32'h10220004, 0, 0, 1'b0);
        issue("j",    32'h08000010, 0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 7);
            fs = $urandom_range(0, 2);
            ms = $urandom_range(0, 2);
            z  = 1'($urandom);
            w  = $urandom;
            case (k)
                0: w = {6'h00, w[25:11], 5'h00, 6'h21};
                1: w = {6'h00, w[25:11], 5'h00, 6'h23};
                2: w[31:26] = 6'h0D;
                3: w[31:26] = 6'h0F;
                4: w[31:26] = 6'h23;
                5: w[31:26] = 6'h2B;
                6: w[31:26] = 6'h04;
                default: w[31:26] = 6'h02;
            endcase
            issue(names[k], w, fs, (k == 4 || k == 5) ? ms : 0, z);
        end
        drain();

        // Unsupported opcode: trap is sticky and the counter freezes.
        chk("pre_trap_fetch", int'(bus.imem_read), 1);
        bus.instr = 32'hFC000000;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = 1'($urandom);
            bus.alu_zero  = 1'($urandom);
            tick();
        end
        chk("trap_illegal", int'(bus.illegal_instr), 1);
        chk("trap_retire_frozen", int'(bus.retire_count), exp_cnt);
        chk_quiet("trap");

        #2 reset = 1'b1;
        #1;
        chk("trap_reset_illegal", int'(bus.illegal_instr), 0);
        chk("trap_reset_count", int'(bus.retire_count), 0);
        chk_quiet("trap_reset");
        bus.mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk("trap_recover_imem_read", int'(bus.imem_read), 1);

        // sw aborted by reset while waiting in the data-write phase.
        issue("addu", 32'h00221821, 0, 0, 1'b0);
        drain();
        bus.instr = 32'hAC040008;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_write; i++) tick();
        tick();
        chk("sw_stall_mem_write", int'(bus.mem_write), 1);
        #2 reset = 1'b1;
        #1;
        chk("sw_abort_mem_write", int'(bus.mem_write), 0);
        chk("sw_abort_count", int'(bus.retire_count), 0);
        chk_quiet("sw_abort");
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        issue("subu", 32'h00221823, 1, 0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
